uart_dma_sched: RTL and testbench

- DMA scheduler and APB master that services the UART's dma_tx_req/dma_rx_req handshakes.
- Moves bytes from a streaming source into the UART TX data register (BASE_ADDR+0x44).
- Moves bytes from the UART RX data register (BASE_ADDR+0x34) to a streaming sink.
- Arbitrates TX and RX round-robin, runs a programmed byte count per channel, returns dma_*_acka per byte.

---
 rtl/uart_dma_sched_if.sv | 23 ++
 rtl/uart_dma_sched.sv | 198 +++++++++++++++++++
 tb/tb_uart_dma_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_dma_sched_if.sv
// APB master bus between the DMA scheduler and the UART register block.
interface uart_dma_sched_if;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  modport master (
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
    input  m_prdata, m_pready, m_pslverr
  );

  modport slave (
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/uart_dma_sched.sv
// DMA scheduler for the UART: round-robin TX/RX arbitration, one APB access
// per byte, per-channel byte counters, ack holdoff and sink push stage.
module uart_dma_sched #(
  parameter logic [31:0] BASE_ADDR   = 32'hC3000000,
  parameter logic [31:0] TX_OFFSET   = 32'h44,
  parameter logic [31:0] RX_OFFSET   = 32'h34,
  parameter int          CNT_W       = 16,
  parameter int          ACK_HOLDOFF = 2
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             tx_start,
  input  logic [CNT_W-1:0] tx_len,
  input  logic             rx_start,
  input  logic [CNT_W-1:0] rx_len,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  output logic             src_ready,
  output logic             snk_valid,
  output logic [7:0]       snk_data,
  input  logic             snk_ready,
  input  logic             dma_tx_req,
  input  logic             dma_rx_req,
  output logic             dma_tx_acka,
  output logic             dma_rx_acka,
  uart_dma_sched_if.master apb,
  output logic             busy,
  output logic             tx_done,
  output logic             rx_done,
  output logic             err
);

  localparam int HO_W = (ACK_HOLDOFF < 1) ? 1 : $clog2(ACK_HOLDOFF + 1);
  localparam logic [31:0] TX_ADDR = BASE_ADDR + TX_OFFSET;
  localparam logic [31:0] RX_ADDR = BASE_ADDR + RX_OFFSET;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ACK,
    ST_PUSH
  } state_t;

  state_t state_reg, state_next;

  // Channel index 0 = TX, 1 = RX throughout.
  logic             chan_reg;      // channel currently granted
  logic             last_rx_reg;   // last grant went to RX
  logic [7:0]       byte_reg;      // TX byte to write or RX byte read back
  logic             xfer_err_reg;  // current byte hit a slave error
  logic             err_reg;

  logic [CNT_W-1:0] rem_reg [2];
  logic [HO_W-1:0]  ho_reg  [2];
  logic [1:0]       start_vec;
  logic [CNT_W-1:0] len_vec [2];

  logic tx_elig, rx_elig, grant_any, grant_rx;
  logic access_done, slv_err_hit, ack_cycle;

  assign start_vec  = {rx_start, tx_start};
  assign len_vec[0] = tx_len;
  assign len_vec[1] = rx_len;

  assign tx_elig   = dma_tx_req && (rem_reg[0] != '0) && src_valid && (ho_reg[0] == '0);
  assign rx_elig   = dma_rx_req && (rem_reg[1] != '0) && (ho_reg[1] == '0);
  assign grant_any = tx_elig || rx_elig;
  // On a tie the channel that was not granted last wins.
  assign grant_rx  = rx_elig && (!tx_elig || !last_rx_reg);

  assign access_done = (state_reg == ST_ACCESS) && apb.m_pready;
  assign slv_err_hit = access_done && apb.m_pslverr;
  assign ack_cycle   = (state_reg == ST_ACK);

  // State register.
  always_ff @(posedge pclk) begin
    if (prst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (grant_any) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (apb.m_pready) state_next = ST_ACK;
      ST_ACK:    state_next = (chan_reg && !xfer_err_reg) ? ST_PUSH : ST_IDLE;
      ST_PUSH:   if (snk_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, byte capture and error tracking.
  always_ff @(posedge pclk) begin
    if (prst) begin
      chan_reg     <= 1'b0;
      last_rx_reg  <= 1'b0;
      byte_reg     <= 8'h00;
      xfer_err_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && grant_any) begin
        chan_reg     <= grant_rx;
        last_rx_reg  <= grant_rx;
        xfer_err_reg <= 1'b0;
        if (!grant_rx) byte_reg <= src_data;
      end
      if (access_done) begin
        if (chan_reg) byte_reg <= apb.m_prdata[7:0];
        if (apb.m_pslverr) begin
          xfer_err_reg <= 1'b1;
          err_reg      <= 1'b1;
        end
      end
    end
  end

  // Per-channel remaining count and post-ack holdoff.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic is_mine;
      assign is_mine = (chan_reg == 1'(gi));

      // Remaining bytes: error clears, ack decrements, start loads only when idle-at-zero.
      always_ff @(posedge pclk) begin
        if (prst)
          rem_reg[gi] <= '0;
        else if (slv_err_hit && is_mine)
          rem_reg[gi] <= '0;
        else if (ack_cycle && is_mine && !xfer_err_reg && rem_reg[gi] != '0)
          rem_reg[gi] <= rem_reg[gi] - CNT_W'(1);
        else if (start_vec[gi] && rem_reg[gi] == '0 && len_vec[gi] != '0)
          rem_reg[gi] <= len_vec[gi];
      end

      // Holdoff reloads on this channel's ack and otherwise counts down to zero.
      always_ff @(posedge pclk) begin
        if (prst)
          ho_reg[gi] <= '0;
        else if (ack_cycle && is_mine)
          ho_reg[gi] <= HO_W'(ACK_HOLDOFF);
        else if (ho_reg[gi] != '0)
          ho_reg[gi] <= ho_reg[gi] - HO_W'(1);
      end
    end
  endgenerate

  // Output decode from state, granted channel and captured byte.
  always_comb begin
    apb.m_psel    = 1'b0;
    apb.m_penable = 1'b0;
    apb.m_pwrite  = 1'b0;
    apb.m_paddr   = 32'h0;
    apb.m_pwdata  = 32'h0;
    apb.m_pstrb   = 4'h0;
    apb.m_pprot   = 3'b000;
    src_ready     = 1'b0;
    snk_valid     = 1'b0;
    snk_data      = 8'h00;
    dma_tx_acka   = 1'b0;
    dma_rx_acka   = 1'b0;
    tx_done       = 1'b0;
    rx_done       = 1'b0;
    case (state_reg)
      ST_IDLE: src_ready = grant_any && !grant_rx;
      ST_SETUP, ST_ACCESS: begin
        apb.m_psel    = 1'b1;
        apb.m_penable = (state_reg == ST_ACCESS);
        if (!chan_reg) begin
          apb.m_pwrite = 1'b1;
          apb.m_paddr  = TX_ADDR;
          apb.m_pwdata = {24'h0, byte_reg};
          apb.m_pstrb  = 4'h1;
        end else begin
          apb.m_paddr  = RX_ADDR;
        end
      end
      ST_ACK: begin
        dma_tx_acka = !chan_reg;
        dma_rx_acka = chan_reg;
        tx_done     = !chan_reg && !xfer_err_reg && (rem_reg[0] == CNT_W'(1));
        rx_done     = chan_reg && !xfer_err_reg && (rem_reg[1] == CNT_W'(1));
      end
      ST_PUSH: begin
        snk_valid = 1'b1;
        snk_data  = byte_reg;
      end
      default: ;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);
  assign err  = err_reg;

endmodule

// File: tb/tb_uart_dma_sched.sv
// Scoreboard bench for uart_dma_sched: stimulus queues expected APB accesses,
// acks and sink bytes; a negedge monitor pops and compares them.
module tb_uart_dma_sched;

  logic        pclk = 1'b0;
  logic        prst;
  logic        tx_start, rx_start;
  logic [15:0] tx_len, rx_len;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_ready;
  logic        snk_valid;
  logic [7:0]  snk_data;
  logic        snk_ready;
  logic        dma_tx_req, dma_rx_req;
  logic        dma_tx_acka, dma_rx_acka;
  logic        busy, tx_done, rx_done, err;

  uart_dma_sched_if bus ();

  uart_dma_sched dut (
    .pclk(pclk), .prst(prst),
    .tx_start(tx_start), .tx_len(tx_len),
    .rx_start(rx_start), .rx_len(rx_len),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .dma_tx_req(dma_tx_req), .dma_rx_req(dma_rx_req),
    .dma_tx_acka(dma_tx_acka), .dma_rx_acka(dma_rx_acka),
    .apb(bus.master),
    .busy(busy), .tx_done(tx_done), .rx_done(rx_done), .err(err)
  );

  always #5 pclk = ~pclk;

  // ---------------- bench-side source, APB slave ----------------
  logic [7:0] src_tbl [8];
  logic [7:0] rd_tbl  [8];
  logic [2:0] src_idx, rd_idx;
  int         ws_cfg, ws_cnt, cyc;
  logic       slverr_cfg;

  assign src_data        = src_tbl[src_idx];
  assign bus.m_pready    = (ws_cnt == 0);
  assign bus.m_prdata    = {24'hA5A5A5, rd_tbl[rd_idx]};
  assign bus.m_pslverr   = slverr_cfg && bus.m_pready;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (prst) begin
      src_idx <= '0;
      rd_idx  <= '0;
    end else begin
      if (src_ready) src_idx <= src_idx + 3'd1;
      if (bus.m_psel && bus.m_penable && bus.m_pready && !bus.m_pwrite) rd_idx <= rd_idx + 3'd1;
    end
  end

  always @(posedge pclk) begin
    if (!bus.m_psel)                                ws_cnt <= ws_cfg;
    else if (bus.m_penable && ws_cnt > 0)           ws_cnt <= ws_cnt - 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } apb_t;

  apb_t       exp_apb [$];
  int         exp_ack [$];   // 0 = TX, 1 = RX
  logic [7:0] exp_snk [$];

  int n_chk = 0;
  int n_fail = 0;
  int tx_done_cnt, rx_done_cnt;
  int last_ack [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_wr(input logic [7:0] b);
    apb_t e;
    e.wr = 1'b1; e.addr = 32'hC300_0044; e.data = {24'h0, b}; e.strb = 4'h1;
    exp_apb.push_back(e);
    exp_ack.push_back(0);
  endtask

  task automatic exp_rd(input logic [7:0] b);
    apb_t e;
    e.wr = 1'b0; e.addr = 32'hC300_0034; e.data = 32'h0; e.strb = 4'h0;
    exp_apb.push_back(e);
    exp_ack.push_back(1);
    exp_snk.push_back(b);
  endtask

  // Monitor: compares every APB access cycle, ack, sink handshake and done pulse.
  initial begin
    apb_t e;
    int   ch;
    forever begin
      @(negedge pclk);
      if (prst) begin
        tx_done_cnt = 0;
        rx_done_cnt = 0;
        last_ack[0] = -1000;
        last_ack[1] = -1000;
      end else begin
        if (bus.m_psel && bus.m_penable) begin
          if (exp_apb.size() == 0) begin
            if (bus.m_pready) chk("apb_unexpected_xfer", bus.m_paddr, 32'hFFFF_FFFF);
          end else begin
            e = exp_apb[0];
            chk("apb_pwrite", {31'h0, bus.m_pwrite}, {31'h0, e.wr});
            chk("apb_paddr", bus.m_paddr, e.addr);
            chk("apb_pstrb", {28'h0, bus.m_pstrb}, {28'h0, e.strb});
            if (e.wr) chk("apb_pwdata", bus.m_pwdata, e.data);
            if (bus.m_pready) void'(exp_apb.pop_front());
          end
        end
        if (dma_tx_acka || dma_rx_acka) begin
          chk("acka_exclusive", {31'h0, dma_tx_acka && dma_rx_acka}, 32'h0);
          ch = dma_rx_acka ? 1 : 0;
          if (exp_ack.size() == 0) chk("acka_unexpected", ch, 32'hFFFF_FFFF);
          else chk("acka_channel", ch, exp_ack.pop_front());
          chk("acka_spacing_ok", {31'h0, (cyc - last_ack[ch]) >= 3}, 32'h1);
          last_ack[ch] = cyc;
        end
        if (snk_valid) begin
          chk("no_apb_during_push", {31'h0, bus.m_psel}, 32'h0);
          if (snk_ready) begin
            if (exp_snk.size() == 0) chk("snk_unexpected", {24'h0, snk_data}, 32'hFFFF_FFFF);
            else chk("snk_data", {24'h0, snk_data}, {24'h0, exp_snk.pop_front()});
          end
        end
        if (tx_done) begin
          tx_done_cnt++;
          chk("tx_done_with_acka", {31'h0, dma_tx_acka}, 32'h1);
        end
        if (rx_done) begin
          rx_done_cnt++;
          chk("rx_done_with_acka", {31'h0, dma_rx_acka}, 32'h1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Bounded wait, sampled on the falling edge.
  task automatic wait_for(input int sel, input int max, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge pclk);
      case (sel)
        0: hit = src_ready;
        1: hit = dma_tx_acka;
        2: hit = dma_rx_acka;
        3: hit = !busy;
        4: hit = snk_valid;
        default: hit = bus.m_psel && bus.m_penable;
      endcase
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_%s: event not seen within %0d cycles", nm, max);
    end
  endtask

  task automatic do_reset();
    prst = 1'b1;
    tick(2);
    prst = 1'b0;
  endtask

  task automatic queues_empty(input string nm);
    chk({nm, "_apb_q_left"}, exp_apb.size(), 0);
    chk({nm, "_ack_q_left"}, exp_ack.size(), 0);
    chk({nm, "_snk_q_left"}, exp_snk.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int g;
    cyc = 0; ws_cfg = 0; slverr_cfg = 1'b0;
    prst = 1'b1; tx_start = 0; rx_start = 0; tx_len = 0; rx_len = 0;
    src_valid = 0; snk_ready = 0; dma_tx_req = 0; dma_rx_req = 0;
    for (int i = 0; i < 8; i++) begin src_tbl[i] = 8'h00; rd_tbl[i] = 8'h00; end
    tick(3);
    prst = 1'b0;

    // Reset state
    @(negedge pclk);
    chk("rst_psel", {31'h0, bus.m_psel}, 0);
    chk("rst_penable", {31'h0, bus.m_penable}, 0);
    chk("rst_paddr", bus.m_paddr, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_outs", {26'h0, src_ready, snk_valid, dma_tx_acka, dma_rx_acka, tx_done, rx_done}, 0);
    $display("reset state checked");

    // Test 1: single TX byte, zero-wait APB, 3-cycle grant-to-ack latency
    tick(1);
    src_tbl[0] = 8'h89;
    exp_wr(8'h89);
    tx_len = 16'd1; tx_start = 1; src_valid = 1; dma_tx_req = 1;
    tick(1);
    tx_start = 0;
    wait_for(0, 20, "tx1_grant");
    g = cyc;
    wait_for(1, 20, "tx1_acka");
    chk("tx1_grant_to_acka", cyc - g, 3);
    tick(1);
    dma_tx_req = 0; src_valid = 0;
    wait_for(3, 20, "tx1_idle");
    chk("tx1_done_count", tx_done_cnt, 1);
    queues_empty("tx1");
    $display("txn tx1: wrote 0x89 to 0xC3000044");

    // Test 2: three RX bytes, sink stalls 5 cycles each
    do_reset();
    rd_tbl[0] = 8'h55; rd_tbl[1] = 8'hAA; rd_tbl[2] = 8'h0F;
    exp_rd(8'h55); exp_rd(8'hAA); exp_rd(8'h0F);
    rx_len = 16'd3; rx_start = 1; dma_rx_req = 1; snk_ready = 0;
    tick(1);
    rx_start = 0;
    for (int k = 0; k < 3; k++) begin
      wait_for(4, 30, "rx_snk_valid");
      tick(5);
      @(negedge pclk);
      chk("rx_snk_held", {31'h0, snk_valid}, 1);
      tick(1);
      snk_ready = 1;
      tick(1);
      snk_ready = 0;
      $display("txn rx byte %0d delivered", k);
    end
    wait_for(3, 20, "rx_idle");
    dma_rx_req = 0;
    chk("rx_done_count", rx_done_cnt, 1);
    queues_empty("rx");

    // Test 3: contention, grants alternate RX,TX,...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd_tbl[i]  = 8'hC0 + 8'(i);
      src_tbl[i] = 8'hD0 + 8'(i);
    end
    for (int i = 0; i < 4; i++) begin
      exp_rd(8'hC0 + 8'(i));
      exp_wr(8'hD0 + 8'(i));
    end
    tx_len = 16'd4; rx_len = 16'd4; tx_start = 1; rx_start = 1;
    src_valid = 1; snk_ready = 1; dma_tx_req = 1; dma_rx_req = 1;
    tick(1);
    tx_start = 0; rx_start = 0;
    for (int k = 0; k < 8; k++) begin
      wait_for(k[0] ? 1 : 2, 40, "cont_acka");
      $display("txn contention ack %0d (%s)", k, k[0] ? "TX" : "RX");
    end
    wait_for(3, 20, "cont_idle");
    tick(10);
    chk("cont_tx_done", tx_done_cnt, 1);
    chk("cont_rx_done", rx_done_cnt, 1);
    queues_empty("cont");
    dma_tx_req = 0; dma_rx_req = 0; src_valid = 0; snk_ready = 0;

    // Test 4: TX with 4 wait states then slave error
    do_reset();
    ws_cfg = 4; slverr_cfg = 1'b1;
    src_tbl[0] = 8'h3C;
    exp_wr(8'h3C);
    tx_len = 16'd2; tx_start = 1; src_valid = 1; dma_tx_req = 1;
    tick(1);
    tx_start = 0;
    wait_for(1, 40, "err_acka");
    chk("err_at_ack", {31'h0, err}, 1);
    tick(15);
    chk("err_sticky", {31'h0, err}, 1);
    chk("err_busy", {31'h0, busy}, 0);
    chk("err_no_tx_done", tx_done_cnt, 0);
    queues_empty("err");
    $display("txn err: write of 0x3C errored, channel stopped");
    slverr_cfg = 1'b0;

    // Test 6: reset in the middle of an ACCESS with wait states
    for (int i = 0; i < 8; i++) src_tbl[i] = 8'h77;
    ws_cfg = 5;
    exp_wr(8'h77);
    tx_len = 16'd3; tx_start = 1;
    tick(1);
    tx_start = 0;
    wait_for(5, 20, "mid_access");
    tick(1);
    prst = 1'b1;
    exp_apb.delete(); exp_ack.delete(); exp_snk.delete();
    tick(1);
    prst = 1'b0;
    @(negedge pclk);
    chk("mid_rst_psel", {31'h0, bus.m_psel}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_err", {31'h0, err}, 0);
    chk("mid_rst_acka", {30'h0, dma_tx_acka, dma_rx_acka}, 0);
    ws_cfg = 0;
    tick(20);
    chk("mid_rst_idle_after", {31'h0, busy}, 0);
    queues_empty("mid_rst");
    $display("txn reset mid-access: bus released, counters cleared");
    dma_tx_req = 0; src_valid = 0;

    // Test 5: starts while active or with zero length are ignored
    do_reset();
    src_tbl[0] = 8'hA1; src_tbl[1] = 8'hA2;
    tx_len = 16'd2; tx_start = 1;
    tick(1);
    tx_len = 16'd7;
    tick(1);
    tx_len = 16'd0;
    tick(1);
    tx_start = 0;
    exp_wr(8'hA1); exp_wr(8'hA2);
    dma_tx_req = 1; src_valid = 1;
    wait_for(1, 30, "restart_acka1");
    wait_for(1, 30, "restart_acka2");
    tick(20);
    chk("restart_done", tx_done_cnt, 1);
    tx_len = 16'd0; tx_start = 1;
    tick(1);
    tx_start = 0;
    tick(20);
    chk("zero_len_no_done", tx_done_cnt, 1);
    chk("zero_len_busy", {31'h0, busy}, 0);
    queues_empty("restart");
    $display("txn restart: exactly two bytes sent");
    dma_tx_req = 0; src_valid = 0;

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
